// File: rtl/zle_pkg.sv
// ---------------------------------------------------------------------------
// zle_pkg
// Shared definitions for the zero run-length (ZLE) token format and the
// decoder's output state.
//   DW        : data word width; tokens are DW+1 bits wide.
//   KIND_BIT  : token bit selecting literal (0) or zero-run (1).
//   PAY_MSB/PAY_LSB : payload slice of a token.
//   TOK_LIT/TOK_RUN : kind encodings.
//   zle_state_e     : EMPTY / HOLD / RUN view of the output slot.
// ---------------------------------------------------------------------------
package zle_pkg;

    localparam int DW       = 3;
    localparam int TW       = DW + 1;
    localparam int KIND_BIT = DW;
    localparam int PAY_MSB  = DW - 1;
    localparam int PAY_LSB  = 0;

    localparam logic TOK_LIT = 1'b0;
    localparam logic TOK_RUN = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,   // no word presented
        ST_HOLD  = 2'b01,   // one word presented, nothing owed after it
        ST_RUN   = 2'b10    // zero presented, more zeros owed
    } zle_state_e;

endpackage

// File: rtl/zle_dec_fsm.sv
// ---------------------------------------------------------------------------
// zle_dec_fsm
// Control half of the ZLE decoder. Owns the output-valid register and
// derives the EMPTY/HOLD/RUN state, the producer back-pressure and the
// accept/consume strobes that steer the datapath in zle_dec.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_v_i        : token valid from producer
//   o_b_i        : back-pressure from consumer
//   cnt_zero_i   : datapath owes no further zeros
//   state_o      : current output-slot state
//   i_b_o        : back-pressure to producer (combinational)
//   accept_o     : token taken on this edge
//   consume_o    : presented word taken on this edge
//   out_v_o      : registered output valid
// ---------------------------------------------------------------------------
module zle_dec_fsm
    import zle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_v_i,
    input  logic       o_b_i,
    input  logic       cnt_zero_i,
    output zle_state_e state_o,
    output logic       i_b_o,
    output logic       accept_o,
    output logic       consume_o,
    output logic       out_v_o
);

    logic out_v_q;

    always_comb begin
        if (!out_v_q)        state_o = ST_EMPTY;
        else if (cnt_zero_i) state_o = ST_HOLD;
        else                 state_o = ST_RUN;
    end

    assign consume_o = out_v_q & ~o_b_i;
    // Accept only with no run pending and the slot empty or draining now,
    // so a new token can load on the same edge the last word leaves.
    assign i_b_o     = ~cnt_zero_i | (out_v_q & o_b_i);
    assign accept_o  = i_v_i & ~i_b_o;
    assign out_v_o   = out_v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
        end else if (accept_o) begin
            out_v_q <= 1'b1;
        end else if (consume_o && cnt_zero_i) begin
            out_v_q <= 1'b0;
        end
    end

endmodule

// File: rtl/zle_dec.sv
// ---------------------------------------------------------------------------
// zle_dec
// Zero run-length decoder. Expands literal / zero-run tokens back into a
// stream of DW-bit words, up to one word per cycle, with valid/back-pressure
// handshakes on both sides.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_d [DW:0] : token; bit DW = kind (0 literal, 1 run), low bits payload
//   i_v        : token valid
//   i_b        : back-pressure to token producer
//   o_d [DW-1:0] : decoded word (registered)
//   o_v        : output valid (registered)
//   o_b        : back-pressure from consumer
// A run token with payload p emits p+1 zeros.
// ---------------------------------------------------------------------------
module zle_dec
    import zle_pkg::*;
#(
    parameter int DW = zle_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW:0]   i_d,
    input  logic          i_v,
    output logic          i_b,
    output logic [DW-1:0] o_d,
    output logic          o_v,
    input  logic          o_b
);

    logic [DW-1:0] out_d_q, out_d_d;
    logic [DW-1:0] cnt_q, cnt_d;   // zeros still owed after the presented word
    logic          cnt_zero;
    logic          accept, consume;
    zle_state_e    state;

    assign cnt_zero = (cnt_q == '0);

    zle_dec_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_v_i      (i_v),
        .o_b_i      (o_b),
        .cnt_zero_i (cnt_zero),
        .state_o    (state),
        .i_b_o      (i_b),
        .accept_o   (accept),
        .consume_o  (consume),
        .out_v_o    (o_v)
    );

    always_comb begin
        out_d_d = out_d_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (i_d[DW] == TOK_RUN) begin
                // First zero of the run is presented now; payload more follow.
                out_d_d = '0;
                cnt_d   = i_d[DW-1:0];
            end else begin
                out_d_d = i_d[DW-1:0];
                cnt_d   = '0;
            end
        end else if (consume && state == ST_RUN) begin
            // cnt is non-zero in RUN, so this never wraps.
            out_d_d = '0;
            cnt_d   = cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_d_q <= '0;
            cnt_q   <= '0;
        end else begin
            out_d_q <= out_d_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_d = out_d_q;

endmodule
